// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - MIPS register file with pending-write scoreboard; optional RF_BYPASS_EN write-to-read forwarding
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read1,
  output logic [DATA_W-1:0] data1,
  output logic              busy1,
  input  logic [ADDR_W-1:0] read2,
  output logic [DATA_W-1:0] data2,
  output logic              busy2,
  input  logic              write,
  input  logic [ADDR_W-1:0] reg_write,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mark,
  input  logic [ADDR_W-1:0] mark_addr,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;

  logic wr_en, mk_en, set_new, clr_old;

  assign wr_en = write && (reg_write != '0);
  assign mk_en = mark && (mark_addr != '0);

  // A mark only counts when it claims a free register; a write only uncounts
  // when it frees a busy register that is not re-claimed in the same cycle.
  assign set_new = mk_en && !busy_q[mark_addr];
  assign clr_old = wr_en && busy_q[reg_write] && !(mk_en && (mark_addr == reg_write));

  // Next busy vector: write clears first so a same-address mark wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[reg_write] = 1'b0;
    if (mk_en) busy_d[mark_addr] = 1'b1;
  end

  // Next pending count tracks the popcount of busy_d incrementally.
  always_comb begin
    pend_cnt_d = pend_cnt_q;
    if (set_new && !clr_old)      pend_cnt_d = pend_cnt_q + (ADDR_W+1)'(1);
    else if (clr_old && !set_new) pend_cnt_d = pend_cnt_q - (ADDR_W+1)'(1);
  end

  // Register array, busy bits and count; reset overrides write and mark.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      if (wr_en) regs_q[reg_write] <= wdata;
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt = pend_cnt_q;

  // Read port 1: r0 reads as idle zero; optional same-cycle forwarding.
  always_comb begin
    data1 = '0;
    busy1 = 1'b0;
    if (read1 != '0) begin
      data1 = regs_q[read1];
      busy1 = busy_q[read1];
`ifdef RF_BYPASS_EN
      if (wr_en && (read1 == reg_write)) begin
        data1 = wdata;
        busy1 = 1'b0;
      end
`endif
    end
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    data2 = '0;
    busy2 = 1'b0;
    if (read2 != '0) begin
      data2 = regs_q[read2];
      busy2 = busy_q[read2];
`ifdef RF_BYPASS_EN
      if (wr_en && (read2 == reg_write)) begin
        data2 = wdata;
        busy2 = 1'b0;
      end
`endif
    end
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised MIPS general-purpose register file with a clocked write port, two combinational read ports, and a per-register pending-write scoreboard. It sits between decode and writeback. Decode marks a destination register busy when a long-latency producer (load, multiply) issues. Writeback clears the busy bit when it writes the result. Read ports return data plus a busy flag so the hazard unit can stall on load-use dependencies.

## Interface
Parameters:
- DATA_W, 32, width of each register and of the data ports
- ADDR_W, 5, register address width; depth = 2**ADDR_W; register 0 is hardwired zero

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  input  1  clock; all state updates on rising edge
  - rst  input  1  synchronous active-high reset
- Read port 1:
  - read1  input  ADDR_W  read port 1 address
  - data1  output  DATA_W  read port 1 data (combinational)
  - busy1  output  1  read port 1 register has a pending write
- Read port 2:
  - read2  input  ADDR_W  read port 2 address
  - data2  output  DATA_W  read port 2 data (combinational)
  - busy2  output  1  read port 2 register has a pending write
- Write port:
  - write  input  1  write enable
  - reg_write  input  ADDR_W  write address
  - wdata  input  DATA_W  write data
- Scoreboard and status:
  - mark  input  1  set pending bit for mark_addr
  - mark_addr  input  ADDR_W  register being claimed by a new producer
  - pend_cnt  output  ADDR_W+1  number of registers currently pending (registered)

## Operation
- State: array of 2**ADDR_W registers of DATA_W bits; busy bit vector of 2**ADDR_W; pend_cnt counter.
- Write: at a rising edge with write=1 and reg_write≠0, reg[reg_write] ← wdata and busy[reg_write] ← 0. A write to address 0 is discarded.
- Mark: at a rising edge with mark=1 and mark_addr≠0, busy[mark_addr] ← 1. A mark on address 0 is ignored. A mark on an already-busy register changes nothing.
- Mark and write to the same address in the same cycle: the data is written and busy ends at 1, because the newer producer wins.
- Mark and write to different addresses in the same cycle: both take effect.
- Read: dataN = 0 and busyN = 0 when readN = 0. Otherwise dataN = reg[readN] and busyN = busy[readN], subject to bypass (see Configuration).
- pend_cnt always equals the popcount of the busy vector after each edge. It increments on a mark that sets a previously clear bit. It decrements on a write that clears a set bit, excluding the mark-wins case. It is unchanged when both happen on different registers. It never exceeds 2**ADDR_W−1.
- Reset: rst=1 at an edge zeroes every register, every busy bit and pend_cnt. Reset has priority over write and mark in the same cycle.

## Timing
- Write latency: a written value is visible from the array one cycle after the edge, and in the same cycle through bypass when enabled.
- Mark latency: busyN rises in the cycle after the mark edge.
- Clear latency: busyN falls in the cycle after the write edge, or in the same cycle through bypass when enabled.
- Read paths are purely combinational, with no read latency and no handshake.
- After reset: data1 = data2 = 0, busy1 = busy2 = 0, pend_cnt = 0.
- Reset mid-operation: pending marks are lost. A write in the reset cycle is dropped.

## Configuration
- RF_BYPASS_EN defined: when write=1, reg_write≠0 and readN = reg_write, dataN = wdata and busyN = 0 combinationally in the same cycle.
- RF_BYPASS_EN undefined: no forwarding. dataN shows the old array value and busyN the old busy bit until the edge. Writeback must then happen one stage ahead of the reads, or the hazard unit must stall one extra cycle.
- The macro has no effect on sequential state, pend_cnt, or register-0 behaviour.

## Test plan
- Reset then read all addresses: every dataN = 0, busyN = 0, pend_cnt = 0.
- Write 0xDEADBEEF to r5, read r5 on both ports next cycle: data = 0xDEADBEEF. In the same cycle, with RF_BYPASS_EN, data1 = 0xDEADBEEF; without it, data1 = 0.
- Write 0x1234 to r0, read r0: data = 0. Mark r0: busy = 0 and pend_cnt stays 0.
- Mark r3 and r7 on consecutive cycles: busy on r3 and r7 = 1, pend_cnt = 2. Then write r3 = 0x55 while marking r9: pend_cnt = 2, busy on r3 = 0, busy on r9 = 1.
- Mark r4 and write r4 = 0xAA in the same cycle: next cycle data = 0xAA, busy = 1, pend_cnt increments by 1.
- Mark r2 and write r6, then assert rst with write r6 = 0x77 and mark r8 in the same cycle: next cycle all data = 0, all busy = 0, pend_cnt = 0.
